// File: rtl/xregf_mp_pkg.sv
// Shared definitions for the xregf_mp register file.
//   XREGF_DATA_W / XREGF_ADDR_W : default word width and address width
//   seq_state_e                 : clear-sweep sequencer states
//   strb_w()                    : byte-strobe count for a given word width
package xregf_mp_pkg;

  localparam int XREGF_DATA_W = 32;
  localparam int XREGF_ADDR_W = 4;

  typedef enum logic {
    SEQ_IDLE  = 1'b0,
    SEQ_SWEEP = 1'b1
  } seq_state_e;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/xregf_mp_if.sv
// Host bus for xregf_mp: one strobed write port, two read ports, clear/busy.
//   master : controller side (drives sel/we/wstrb/waddr/wdata/raddr_*/clr)
//   slave  : register file side (drives rdata_a/rdata_b/busy)
interface xregf_mp_if
  import xregf_mp_pkg::*;
#(
  parameter int DATA_W = XREGF_DATA_W,
  parameter int ADDR_W = XREGF_ADDR_W
);
  logic                        sel;
  logic                        we;
  logic [strb_w(DATA_W)-1:0]   wstrb;
  logic [ADDR_W-1:0]           waddr;
  logic [DATA_W-1:0]           wdata;
  logic [ADDR_W-1:0]           raddr_a;
  logic [DATA_W-1:0]           rdata_a;
  logic [ADDR_W-1:0]           raddr_b;
  logic [DATA_W-1:0]           rdata_b;
  logic                        clr;
  logic                        busy;

  modport master (
    output sel, we, wstrb, waddr, wdata, raddr_a, raddr_b, clr,
    input  rdata_a, rdata_b, busy
  );

  modport slave (
    input  sel, we, wstrb, waddr, wdata, raddr_a, raddr_b, clr,
    output rdata_a, rdata_b, busy
  );
endinterface

// File: rtl/xregf_mp_clr_seq.sv
// Clear-sweep sequencer: walks a pointer across every entry, one per cycle,
// after reset release or on an accepted clear request.
//   clk, rst     : system clock, async active-low reset
//   i_start      : accepted clear request (already qualified with sel/!busy)
//   o_busy       : sweep in progress
//   o_clr_we     : zero-write enable for the array
//   o_clr_addr   : entry being zeroed this cycle
//
// state     | meaning
// SEQ_IDLE  | no sweep, pointer parked at 0, waiting for i_start
// SEQ_SWEEP | zeroing entry r_ptr this cycle, leaves after the last entry
module xregf_clr_seq
  import xregf_mp_pkg::*;
#(
  parameter int ADDR_W = XREGF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_ptr;

  // Reset lands directly in SWEEP so the array is scrubbed after every reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEQ_SWEEP;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (i_start) begin
            r_state <= SEQ_SWEEP;
            r_ptr   <= '0;
          end
        end
        SEQ_SWEEP: begin
          r_ptr <= r_ptr + 1'b1;           // wraps to 0 after LAST_ADDR
          if (r_ptr == LAST_ADDR) r_state <= SEQ_IDLE;
        end
        default: begin
          r_state <= SEQ_IDLE;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  assign o_busy     = (r_state == SEQ_SWEEP);
  assign o_clr_we   = (r_state == SEQ_SWEEP);
  assign o_clr_addr = r_ptr;

endmodule

// File: rtl/xregf_mp.sv
// Two-read / one-write register file with byte strobes, optional write-to-read
// bypass and a built-in clear sweep.
//   clk, rst : system clock, async active-low reset
//   bus      : xregf_mp_if slave (sel/we/wstrb/waddr/wdata/raddr_a/raddr_b/clr
//              in, rdata_a/rdata_b/busy out)
// Reads are combinational and forced to 0 while deselected or sweeping.
module xregf_mp
  import xregf_mp_pkg::*;
#(
  parameter int DATA_W = XREGF_DATA_W,
  parameter int ADDR_W = XREGF_ADDR_W,
  parameter int BYPASS = 0
) (
  input  logic        clk,
  input  logic        rst,
  xregf_mp_if.slave   bus
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int STRB_W = strb_w(DATA_W);

  logic [DATA_W-1:0] r_regf [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_host_we;
  logic              w_start;
  logic              w_rd_en;
  logic              w_hit_a;
  logic              w_hit_b;
  logic [DATA_W-1:0] w_merged;

  assign w_host_we = bus.sel & bus.we & ~w_busy;
  assign w_start   = bus.sel & bus.clr & ~w_busy;
  assign w_rd_en   = bus.sel & ~w_busy;

  xregf_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // Array has no reset; the sweep that follows reset release zeroes it.
  // Sweep writes take priority, though host writes are already blocked by busy.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_regf[w_clr_addr] <= '0;
    end else if (w_host_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (bus.wstrb[i]) r_regf[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Value the written entry will hold after this edge, used for bypass.
  always_comb begin
    w_merged = r_regf[bus.waddr];
    for (int i = 0; i < STRB_W; i++) begin
      if (bus.wstrb[i]) w_merged[8*i +: 8] = bus.wdata[8*i +: 8];
    end
  end

  assign w_hit_a = (BYPASS != 0) && w_host_we && (bus.raddr_a == bus.waddr);
  assign w_hit_b = (BYPASS != 0) && w_host_we && (bus.raddr_b == bus.waddr);

  assign bus.rdata_a = !w_rd_en ? '0 : (w_hit_a ? w_merged : r_regf[bus.raddr_a]);
  assign bus.rdata_b = !w_rd_en ? '0 : (w_hit_b ? w_merged : r_regf[bus.raddr_b]);
  assign bus.busy    = w_busy;

endmodule
